coeff_token_ctrl: RTL and testbench
===================================

COEFF_TOKEN_CTRL -- requirements
Module: coeff_token_ctrl

Interface
REQ-001 SHALL have parameter ERR_TC, default 5'd31: TotalCoeff value that marks an invalid ROM entry.
REQ-002 SHALL have parameter FLC_BITS, default 6: fixed-length code width for nC>=8.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 nReset  input  1  reset, asynchronous, active-low.
REQ-005 Start  input  1  request to decode one coeff_token; accepted only in IDLE.
REQ-006 nC  input  5  unsigned context, 0..16, sampled with accepted Start.
REQ-007 BitWindow  input  16  next 16 bitstream bits, MSB first.
REQ-008 WindowValid  input  1  BitWindow holds at least 16 valid bits.
REQ-009 RomSel  output  2  table select: 0 for nC 0-1, 1 for nC 2-3, 2 for nC 4-7, 3 for nC>=8 (FLC, no ROM).
REQ-010 RomAddr  output  16  registered lookup address to the external ROM mux.
REQ-011 RomTotalCoeff / RomTrailingOnes / RomNumShift  input  5/2/5  combinational ROM result for RomAddr.
REQ-012 ShiftReq  output  1  request to consume ShiftAmt bits.
REQ-013 ShiftAmt  output  5  bits to consume.
REQ-014 ShiftAck  input  1  aligner accepted the shift.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 Done / Error  output  1 / 1  one-cycle completion / invalid-code pulses.
REQ-017 TotalCoeff / TrailingOnes  output  5 / 2  decoded result; held until the next accepted Start.

Function
REQ-018 SHALL implement states IDLE, WAIT_BITS, LOOKUP, SHIFT, DONE.
REQ-019 IDLE->WAIT_BITS on Start: register RomSel from nC; Start outside IDLE is ignored.
REQ-020 WAIT_BITS: hold until WindowValid=1, then register RomAddr<=BitWindow and move to LOOKUP.
REQ-021 LOOKUP, RomSel 0-2: capture ROM outputs. If RomTotalCoeff==ERR_TC or RomNumShift==0: pulse Error, go to IDLE, no ShiftReq. Otherwise go to SHIFT with ShiftAmt<=RomNumShift.
REQ-022 LOOKUP, RomSel=3: decode RomAddr[15:10] as xxxxyy.
- 6'b000011 gives TotalCoeff 0, TrailingOnes 0.
- Otherwise TotalCoeff = xxxx+1 and TrailingOnes = yy.
- yy greater than TotalCoeff raises Error as in REQ-021.
- ShiftAmt = FLC_BITS.
REQ-023 SHIFT: ShiftReq=1 with ShiftAmt stable until a cycle with ShiftAck=1; then go to DONE.
REQ-024 DONE: pulse Done for one cycle, then go to IDLE.
REQ-025 Minimum Start-to-Done latency SHALL be 4 cycles when WindowValid and ShiftAck are already high.
REQ-026 TotalCoeff and TrailingOnes SHALL update only on a successful LOOKUP; Error leaves them unchanged.
REQ-027 Done, Error and ShiftReq SHALL be mutually exclusive in any cycle.

Reset
REQ-028 nReset low SHALL immediately force IDLE, and drive ShiftReq, Done, Error, Busy to 0, RomSel=0, RomAddr=0, ShiftAmt=0, TotalCoeff=0, TrailingOnes=0.
REQ-029 Reset in any state, including SHIFT, SHALL abandon the decode with no ShiftReq after release; the first Start after release SHALL decode normally.

Structure
REQ-030 Shared package cavlc_pkg SHALL hold:
- state enum;
- RomSel encodings;
- ERR_TC default;
- FLC_BITS and the FLC escape code 6'b000011.
REQ-031 The FLC decode SHALL be the sub-module coeff_token_flc (6-bit in; TotalCoeff, TrailingOnes, Invalid out). All other logic is in coeff_token_ctrl.

Verification
REQ-032 nC=3, BitWindow=16'hC000, ROM returns 0/0/2 -> RomSel=1, RomAddr=16'hC000, ShiftReq with ShiftAmt=2, Done 4 cycles after Start, TotalCoeff=0, TrailingOnes=0.
REQ-033 nC=10, BitWindow[15:10]=6'b010111 -> TotalCoeff=6, TrailingOnes=3, ShiftAmt=6. Then 6'b000011 -> TotalCoeff=0, TrailingOnes=0, ShiftAmt=6.
REQ-034 nC=10, BitWindow[15:10]=6'b000010 -> Error pulse, no ShiftReq, outputs unchanged, Busy=0 the next cycle.
REQ-035 nC=5, ROM returns TotalCoeff=31 and NumShift=0 -> RomSel=2, Error pulse, return to IDLE with no ShiftReq.
REQ-036 WindowValid low for 3 cycles after Start, and ShiftAck delayed 2 cycles -> stays in WAIT_BITS for 3 cycles, ShiftReq held 3 cycles with ShiftAmt stable, single Done pulse. A Start while Busy has no effect.
REQ-037 nReset asserted during SHIFT -> ShiftReq falls with no clock edge and all outputs are 0. After release, Start with nC=0 completes normally.

Source files
------------

// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared types and constants for the coeff_token decode controller
package cavlc_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_BITS, LOOKUP, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SEL_NC01 = 2'd0, SEL_NC23 = 2'd1, SEL_NC47 = 2'd2, SEL_FLC = 2'd3} rom_sel_t;
  localparam logic [4:0] ERR_TC_DEF = 5'd31;
  localparam int FLC_BITS_DEF = 6;
  localparam logic [5:0] FLC_ESC = 6'b000011;
  function automatic rom_sel_t sel_from_nc(input logic [4:0] nc);
    return nc < 5'd2 ? SEL_NC01 : nc < 5'd4 ? SEL_NC23 : nc < 5'd8 ? SEL_NC47 : SEL_FLC;
  endfunction
endpackage

// File: rtl/coeff_token_ctrl_if.sv
// coeff_token_ctrl_if: request, bitstream window, ROM lookup, shifter handshake and result bundle.
// master drives start/nc/bit_window/window_valid, the ROM results and shift_ack;
// slave (the controller) drives rom_sel/rom_addr, shift_req/shift_amt, busy/done/error and the result.
interface coeff_token_ctrl_if;
  logic start;
  logic [4:0] nc;
  logic [15:0] bit_window;
  logic window_valid;
  logic [1:0] rom_sel;
  logic [15:0] rom_addr;
  logic [4:0] rom_total_coeff;
  logic [1:0] rom_trailing_ones;
  logic [4:0] rom_num_shift;
  logic shift_req;
  logic [4:0] shift_amt;
  logic shift_ack;
  logic busy;
  logic done;
  logic error;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  modport master (
    output start, nc, bit_window, window_valid, rom_total_coeff, rom_trailing_ones, rom_num_shift, shift_ack,
    input rom_sel, rom_addr, shift_req, shift_amt, busy, done, error, total_coeff, trailing_ones
  );
  modport slave (
    input start, nc, bit_window, window_valid, rom_total_coeff, rom_trailing_ones, rom_num_shift, shift_ack,
    output rom_sel, rom_addr, shift_req, shift_amt, busy, done, error, total_coeff, trailing_ones
  );
endinterface

// File: rtl/coeff_token_flc.sv
// coeff_token_flc: 6-bit fixed-length coeff_token decode (xxxxyy) used when nC >= 8.
// code in; total_coeff, trailing_ones and invalid (trailing ones exceed total) out.
module coeff_token_flc
  import cavlc_pkg::*;
(
  input  logic [5:0] code,
  output logic [4:0] total_coeff,
  output logic [1:0] trailing_ones,
  output logic       invalid
);
  logic esc;
  assign esc = code == FLC_ESC;
  assign total_coeff = esc ? 5'd0 : {1'b0, code[5:2]} + 5'd1;
  assign trailing_ones = esc ? 2'd0 : code[1:0];
  assign invalid = !esc && ({3'b000, code[1:0]} > total_coeff);
endmodule

// File: rtl/coeff_token_ctrl.sv
// coeff_token_ctrl: sequences one coeff_token decode (table select, ROM/FLC lookup, bit consume).
// clk, rst_n (async active-low); bus is the slave side of coeff_token_ctrl_if.
module coeff_token_ctrl
  import cavlc_pkg::*;
#(
  parameter logic [4:0] ERR_TC = ERR_TC_DEF,
  parameter int FLC_BITS = FLC_BITS_DEF
) (
  input logic clk,
  input logic rst_n,
  coeff_token_ctrl_if.slave bus
);
  state_t state;
  logic [4:0] flc_tc;
  logic [1:0] flc_t1;
  logic flc_inv;
  logic flc_sel;
  logic [4:0] lk_tc;
  logic [1:0] lk_t1;
  logic [4:0] lk_amt;
  logic lk_bad;
  coeff_token_flc u_flc (
    .code(bus.rom_addr[15:10]),
    .total_coeff(flc_tc),
    .trailing_ones(flc_t1),
    .invalid(flc_inv)
  );
  always_comb begin
    flc_sel = bus.rom_sel == SEL_FLC;
    lk_tc = flc_sel ? flc_tc : bus.rom_total_coeff;
    lk_t1 = flc_sel ? flc_t1 : bus.rom_trailing_ones;
    lk_amt = flc_sel ? 5'(FLC_BITS) : bus.rom_num_shift;
    lk_bad = flc_sel ? flc_inv : (bus.rom_total_coeff == ERR_TC || bus.rom_num_shift == 5'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.rom_sel <= 2'd0;
      bus.rom_addr <= 16'd0;
      bus.shift_req <= 1'b0;
      bus.shift_amt <= 5'd0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.total_coeff <= 5'd0;
      bus.trailing_ones <= 2'd0;
    end else begin
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.rom_sel <= sel_from_nc(bus.nc);
          bus.busy <= 1'b1;
          state <= WAIT_BITS;
        end
        WAIT_BITS: if (bus.window_valid) begin
          bus.rom_addr <= bus.bit_window;
          state <= LOOKUP;
        end
        LOOKUP: if (lk_bad) begin
          bus.error <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end else begin
          bus.total_coeff <= lk_tc;
          bus.trailing_ones <= lk_t1;
          bus.shift_amt <= lk_amt;
          bus.shift_req <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (bus.shift_ack) begin
          bus.shift_req <= 1'b0;
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coeff_token_ctrl.sv
// tb_coeff_token_ctrl: vector table, reset corner cases and randomized decodes against a reference model
module tb_coeff_token_ctrl;
  import cavlc_pkg::*;
  typedef struct {
    logic [4:0] nc;
    logic [15:0] win;
    logic [4:0] rtc;
    logic [1:0] rt1;
    logic [4:0] rns;
    int wv_dly;
    int ack_dly;
    logic hold;
    logic err;
    logic [4:0] tc;
    logic [1:0] t1;
    logic [4:0] amt;
    logic [1:0] sel;
  } vec_t;
  logic clk;
  logic rst_n;
  int n_cmp = 0;
  int n_fail = 0;
  logic [4:0] ref_tc = 5'd0;
  logic [1:0] ref_t1 = 2'd0;
  vec_t tbl[13];
  coeff_token_ctrl_if bus ();
  coeff_token_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  // Expected decode derived directly from the table-selection and FLC rules.
  function automatic vec_t model(input vec_t v, input logic [4:0] ptc, input logic [1:0] pt1);
    vec_t m = v;
    int code = int'(v.win[15:10]);
    int tc, t1;
    m.sel = v.nc < 2 ? 2'd0 : v.nc < 4 ? 2'd1 : v.nc < 8 ? 2'd2 : 2'd3;
    if (m.sel == 2'd3) begin
      m.amt = 5'd6;
      tc = code == 3 ? 0 : code / 4 + 1;
      t1 = code == 3 ? 0 : code % 4;
      m.err = t1 > tc;
    end else begin
      m.amt = v.rns;
      tc = int'(v.rtc);
      t1 = int'(v.rt1);
      m.err = v.rtc == 5'd31 || v.rns == 5'd0;
    end
    m.tc = m.err ? ptc : 5'(tc);
    m.t1 = m.err ? pt1 : 2'(t1);
    return m;
  endfunction
  task automatic txn(input string tag, input vec_t v);
    int w, s, exp_end, cyc, end_cyc, sreq_cnt;
    logic got_err, excl_ok, amt_ok, busy_end;
    w = v.wv_dly > 1 ? v.wv_dly : 1;
    s = v.ack_dly + 1;
    exp_end = v.err ? w + 2 : w + 2 + s;
    cyc = 0;
    end_cyc = 0;
    sreq_cnt = 0;
    got_err = 1'b0;
    excl_ok = 1'b1;
    amt_ok = 1'b1;
    busy_end = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.nc = v.nc;
    bus.bit_window = v.win;
    bus.window_valid = v.wv_dly == 0;
    bus.shift_ack = v.ack_dly == 0;
    bus.rom_total_coeff = v.rtc;
    bus.rom_trailing_ones = v.rt1;
    bus.rom_num_shift = v.rns;
    while (end_cyc == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (v.hold) bus.nc = 5'd16 - v.nc;
      else bus.start = 1'b0;
      bus.window_valid = cyc >= v.wv_dly;
      if ($countones({bus.done, bus.error, bus.shift_req}) > 1) excl_ok = 1'b0;
      if (bus.shift_req) begin
        sreq_cnt++;
        if (bus.shift_amt !== v.amt) amt_ok = 1'b0;
      end
      bus.shift_ack = v.ack_dly == 0 || sreq_cnt > v.ack_dly;
      if (bus.done || bus.error) begin
        end_cyc = cyc;
        got_err = bus.error;
        busy_end = bus.busy;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_end_cycle"}, end_cyc, exp_end);
    chk({tag, "_error"}, 32'(got_err), 32'(v.err));
    chk({tag, "_busy_at_end"}, 32'(busy_end), 32'(!v.err));
    chk({tag, "_rom_sel"}, 32'(bus.rom_sel), 32'(v.sel));
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'(v.win));
    chk({tag, "_total_coeff"}, 32'(bus.total_coeff), 32'(v.tc));
    chk({tag, "_trailing_ones"}, 32'(bus.trailing_ones), 32'(v.t1));
    chk({tag, "_shift_req_cycles"}, sreq_cnt, v.err ? 0 : s);
    chk({tag, "_shift_amt_stable"}, 32'(amt_ok), 32'd1);
    chk({tag, "_exclusive"}, 32'(excl_ok), 32'd1);
    @(negedge clk);
    bus.window_valid = 1'b0;
    bus.shift_ack = 1'b0;
    chk({tag, "_idle_after"}, 32'({bus.done, bus.error, bus.busy, bus.shift_req}), 32'd0);
    ref_tc = v.tc;
    ref_t1 = v.t1;
  endtask
  initial begin
    vec_t v;
    int k;
    tbl[0]  = '{5'd3,  16'hC000, 5'd0,  2'd0, 5'd2,  0, 0, 1'b0, 1'b0, 5'd0,  2'd0, 5'd2,  2'd1};
    tbl[1]  = '{5'd10, 16'h5C00, 5'd31, 2'd0, 5'd0,  0, 0, 1'b0, 1'b0, 5'd6,  2'd3, 5'd6,  2'd3};
    tbl[2]  = '{5'd10, 16'h0C00, 5'd9,  2'd1, 5'd3,  0, 0, 1'b0, 1'b0, 5'd0,  2'd0, 5'd6,  2'd3};
    tbl[3]  = '{5'd12, 16'h5C00, 5'd0,  2'd0, 5'd0,  0, 0, 1'b0, 1'b0, 5'd6,  2'd3, 5'd6,  2'd3};
    tbl[4]  = '{5'd10, 16'h0800, 5'd4,  2'd1, 5'd5,  0, 0, 1'b0, 1'b1, 5'd6,  2'd3, 5'd0,  2'd3};
    tbl[5]  = '{5'd5,  16'h1111, 5'd31, 2'd1, 5'd0,  0, 0, 1'b0, 1'b1, 5'd6,  2'd3, 5'd0,  2'd2};
    tbl[6]  = '{5'd1,  16'h1234, 5'd7,  2'd2, 5'd9,  3, 2, 1'b1, 1'b0, 5'd7,  2'd2, 5'd9,  2'd0};
    tbl[7]  = '{5'd7,  16'hABCD, 5'd31, 2'd2, 5'd5,  0, 0, 1'b0, 1'b1, 5'd7,  2'd2, 5'd0,  2'd2};
    tbl[8]  = '{5'd4,  16'h0000, 5'd3,  2'd1, 5'd0,  0, 0, 1'b0, 1'b1, 5'd7,  2'd2, 5'd0,  2'd2};
    tbl[9]  = '{5'd16, 16'hFC00, 5'd0,  2'd0, 5'd0,  0, 0, 1'b0, 1'b0, 5'd16, 2'd3, 5'd6,  2'd3};
    tbl[10] = '{5'd2,  16'hFFFF, 5'd1,  2'd1, 5'd1,  1, 1, 1'b0, 1'b0, 5'd1,  2'd1, 5'd1,  2'd1};
    tbl[11] = '{5'd8,  16'h0400, 5'd0,  2'd0, 5'd0,  0, 0, 1'b0, 1'b0, 5'd1,  2'd1, 5'd6,  2'd3};
    tbl[12] = '{5'd0,  16'h0000, 5'd2,  2'd3, 5'd16, 2, 3, 1'b1, 1'b0, 5'd2,  2'd3, 5'd16, 2'd0};
    bus.start = 1'b0;
    bus.nc = 5'd0;
    bus.bit_window = 16'd0;
    bus.window_valid = 1'b0;
    bus.shift_ack = 1'b0;
    bus.rom_total_coeff = 5'd0;
    bus.rom_trailing_ones = 2'd0;
    bus.rom_num_shift = 5'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.error, bus.shift_req, bus.rom_sel, bus.shift_amt, bus.total_coeff, bus.trailing_ones}), 32'd0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) txn($sformatf("vec%0d", i), tbl[i]);
    @(negedge clk);
    bus.start = 1'b1;
    bus.nc = 5'd3;
    bus.bit_window = 16'hC000;
    bus.window_valid = 1'b1;
    bus.shift_ack = 1'b0;
    bus.rom_total_coeff = 5'd5;
    bus.rom_trailing_ones = 2'd1;
    bus.rom_num_shift = 5'd4;
    k = 0;
    while (!bus.shift_req && k < 10) begin
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end
    chk("midshift_reached_shift", 32'(bus.shift_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midshift_reset_shift_req", 32'(bus.shift_req), 32'd0);
    chk("midshift_reset_outputs", 32'({bus.busy, bus.done, bus.error, bus.rom_sel, bus.shift_amt, bus.total_coeff, bus.trailing_ones}), 32'd0);
    chk("midshift_reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.shift_ack = 1'b1;
    k = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.shift_req || bus.busy || bus.done || bus.error) k++;
    end
    chk("post_reset_quiet", k, 0);
    bus.shift_ack = 1'b0;
    ref_tc = 5'd0;
    ref_t1 = 2'd0;
    txn("post_reset", '{5'd0, 16'h1234, 5'd3, 2'd2, 5'd7, 0, 0, 1'b0, 1'b0, 5'd3, 2'd2, 5'd7, 2'd0});
    for (int i = 0; i < 60; i++) begin
      v.nc = 5'($urandom_range(0, 16));
      v.win = 16'($urandom);
      v.rtc = $urandom_range(0, 7) == 0 ? 5'd31 : 5'($urandom);
      v.rt1 = 2'($urandom);
      v.rns = 5'($urandom_range(0, 16));
      v.wv_dly = int'($urandom_range(0, 3));
      v.ack_dly = int'($urandom_range(0, 3));
      v.hold = 1'($urandom_range(0, 1));
      txn($sformatf("rnd%0d", i), model(v, ref_tc, ref_t1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
